mmu_job_scheduler: RTL and testbench
====================================

// Module: mmu_job_scheduler
// PURPOSE
//  Shares the single 2x2 matrix-multiply unit (MMU) between two host requesters. Grants one
//  requester a whole job: 8 operand bytes into operand memory, an MMU start pulse, then 8
//  result bytes streamed back tagged with the requester id. Sits between the host ports and
//  the MMU control/memory; the MMU itself is unchanged.
// PARAMETERS
//  JOB_BYTES    8   operand bytes per job (weights 0-3 at addr 0-3, inputs 4-7) = result bytes
//  DONE_TIMEOUT 15  max cycles in WAIT for mmu_done before the job is aborted
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   2   per-requester operand byte valid
//  req_data       in   16  {req1 byte, req0 byte}
//  req_transpose  in   2   per-requester transpose flag, sampled on the job's first beat
//  req_ready      out  2   operand byte accepted (one-hot, granted requester only)
//  mem_we         out  1   operand memory write strobe
//  mem_waddr      out  3   operand memory address
//  mem_wdata      out  8   operand memory data
//  mmu_start      out  1   one-cycle pulse: operands loaded, MMU may run
//  mmu_transpose  out  1   latched transpose flag of the current job
//  mmu_done       in   1   MMU results valid (level or pulse)
//  res_idx        out  3   selects result byte (0=c00 hi,1=c00 lo,...,7=c11 lo)
//  res_byte       in   8   result byte addressed by res_idx (combinational from MMU)
//  out_valid      out  1   result byte valid
//  out_data       out  8   result byte
//  out_id         out  1   requester owning out_data
//  out_ready      in   1   downstream accepts result byte
//  busy           out  1   state != IDLE
//  timeout_err    out  1   one-cycle pulse on WAIT timeout
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr=0 (req0 preferred), cnt=0, all outputs 0; any partial job
//    discarded, no mmu_start, no result bytes, even if asserted mid-LOAD/WAIT/DRAIN.
//  - States IDLE -> LOAD -> WAIT -> DRAIN -> IDLE; WAIT -> IDLE on timeout.
//  - IDLE: if any req_valid, grant = sole requester, or rr_ptr's requester if both; latched
//    into grant reg, LOAD entered next cycle (1 cycle arbitration latency, no data taken).
//  - LOAD: req_ready[grant]=1, other 0. Beat = req_valid[grant]&req_ready[grant]; on beat
//    mem_we=1, mem_waddr=cnt, mem_wdata=byte (combinational, same cycle), cnt++.
//    First beat (cnt=0) latches mmu_transpose. Dropped valid stalls indefinitely, no timeout.
//    Beat with cnt=JOB_BYTES-1: cnt<=0, mmu_start pulses next cycle, enter WAIT.
//  - WAIT: tmo counter from 0; mmu_done=1 -> DRAIN (earliest the cycle after mmu_start).
//    tmo reaching DONE_TIMEOUT without done -> timeout_err pulse, IDLE, rr_ptr<=~grant.
//  - DRAIN: res_idx=cnt, out_valid=1, out_data=res_byte, out_id=grant. out_valid held, data
//    stable while out_ready=0. Handshake cnt++; on byte 7 -> IDLE, rr_ptr<=~grant, cnt<=0.
//  - Requests from the non-granted port are held off (req_ready=0) until job completes;
//    a requester holding valid in IDLE never starves (RR alternates when both pending).
//  - Counters 3-bit, wrap only via explicit reset to 0; no arithmetic beyond increments.
//  - Back-to-back: IDLE always occupies exactly one cycle between jobs.
// STRUCTURE
//  - Shared package/header mmu_sched_defs: state encodings (S_IDLE,S_LOAD,S_WAIT,S_DRAIN),
//    JOB_BYTES, result byte index map constants.
//  - Sub-module rr_arbiter_2: 2-input round-robin, inputs req[1:0], ptr; output grant id.
//  - Remainder single always block FSM + counters; output decode combinational.
// TESTING
//  1 Reset, req0 sends bytes 1..8 no stalls -> mem writes addr0..7 = 1..8, mmu_start 1
//    cycle after beat 8, done after 3 cycles -> 8 bytes out with out_id=0, res_idx 0..7.
//  2 Both req_valid high from reset -> req0 job first, req1 job second, then req0 again.
//  3 req0 drops valid for 5 cycles after byte 3 -> addr3 written once, no timeout, job ok.
//  4 out_ready toggles 1,0,0,1 during DRAIN -> out_data/res_idx stable when stalled, 8 bytes.
//  5 mmu_done never asserted -> timeout_err pulses after 15 WAIT cycles, IDLE, rr_ptr flips.
//  6 rst asserted after 4 LOAD beats, then req1 full job -> no start from first job,
//    req1 writes addr0..7, req_transpose[1]=1 gives mmu_transpose=1.

Source files
------------

// File: rtl/mmu_sched_defs.sv
// Shared definitions for the MMU job scheduler: state encoding, job sizing, result byte map.
package mmu_sched_defs;

  localparam int unsigned JOB_BYTES        = 8;
  localparam int unsigned CNT_W            = $clog2(JOB_BYTES);
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned NUM_REQ          = 2;
  localparam int unsigned DONE_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Result byte order presented by the MMU on res_idx.
  typedef enum logic [CNT_W-1:0] {
    RES_C00_HI = 3'd0,
    RES_C00_LO = 3'd1,
    RES_C01_HI = 3'd2,
    RES_C01_LO = 3'd3,
    RES_C10_HI = 3'd4,
    RES_C10_LO = 3'd5,
    RES_C11_HI = 3'd6,
    RES_C11_LO = 3'd7
  } res_idx_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin pick: a sole requester wins, the pointer breaks a tie.
module rr_arbiter_2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_grant
);

  always_comb begin
    o_grant = 1'b0;
    case (i_req)
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = i_ptr;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mmu_job_scheduler.sv
// Shares one 2x2 MMU between two host requesters: load 8 operand bytes, start the MMU,
// wait for done, then stream 8 result bytes tagged with the owning requester.
module mmu_job_scheduler
  import mmu_sched_defs::*;
#(
  parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_transpose,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        mem_we,
  output logic [CNT_W-1:0]            mem_waddr,
  output logic [BYTE_W-1:0]           mem_wdata,
  output logic                        mmu_start,
  output logic                        mmu_transpose,
  input  logic                        mmu_done,
  output logic [CNT_W-1:0]            res_idx,
  input  logic [BYTE_W-1:0]           res_byte,
  output logic                        out_valid,
  output logic [BYTE_W-1:0]           out_data,
  output logic                        out_id,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned    TMO_W     = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(JOB_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(DONE_TIMEOUT - 1);

  state_t             r_state;
  logic               r_grant;
  logic               r_rr_ptr;
  logic               r_start;
  logic               r_transpose;
  logic               r_timeout_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [TMO_W-1:0]   r_tmo;

  logic               w_arb_grant;
  logic               w_beat;
  logic               w_load;
  logic               w_drain;
  logic [BYTE_W-1:0]  w_req_byte;

  rr_arbiter_2 u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant)
  );

  assign w_load     = (r_state == S_LOAD);
  assign w_drain    = (r_state == S_DRAIN);
  assign w_req_byte = r_grant ? req_data[2*BYTE_W-1:BYTE_W] : req_data[BYTE_W-1:0];
  assign w_beat     = w_load && req_valid[r_grant];

  // Operand write path is combinational so a byte lands in memory on its handshake cycle.
  assign req_ready     = w_load ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign mem_we        = w_beat;
  assign mem_waddr     = w_beat ? r_cnt : '0;
  assign mem_wdata     = w_beat ? w_req_byte : '0;
  assign mmu_start     = r_start;
  assign mmu_transpose = r_transpose;
  assign res_idx       = w_drain ? r_cnt : '0;
  assign out_valid     = w_drain;
  assign out_data      = w_drain ? res_byte : '0;
  assign out_id        = w_drain ? r_grant : 1'b0;
  assign busy          = (r_state != S_IDLE);
  assign timeout_err   = r_timeout_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant       <= 1'b0;
      r_rr_ptr      <= 1'b0;
      r_start       <= 1'b0;
      r_transpose   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
      r_tmo         <= '0;
    end else begin
      r_start       <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_grant <= w_arb_grant;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            if (r_cnt == '0) r_transpose <= req_transpose[r_grant];
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_tmo   <= '0;
              r_start <= 1'b1;
              r_state <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          // A done level left over from a previous job is ignored during the start pulse.
          if (mmu_done && !r_start) begin
            r_state <= S_DRAIN;
          end else if (r_tmo == TMO_LAST) begin
            r_timeout_err <= 1'b1;
            r_rr_ptr      <= ~r_grant;
            r_state       <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_cnt == RES_C11_LO) begin
              r_cnt    <= '0;
              r_rr_ptr <= ~r_grant;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_job_scheduler.sv
// Directed bench for mmu_job_scheduler: one table-driven job plus hand-written corner sequences.
module tb_mmu_job_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_transpose;
  logic [1:0]  req_ready;
  logic        mem_we;
  logic [2:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mmu_start;
  logic        mmu_transpose;
  logic        mmu_done;
  logic [2:0]  res_idx;
  logic [7:0]  res_byte;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_id;
  logic        out_ready;
  logic        busy;
  logic        timeout_err;

  int n_err = 0;
  int n_chk = 0;

  mmu_job_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_transpose (req_transpose),
    .req_ready     (req_ready),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mmu_start     (mmu_start),
    .mmu_transpose (mmu_transpose),
    .mmu_done      (mmu_done),
    .res_idx       (res_idx),
    .res_byte      (res_byte),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_id        (out_id),
    .out_ready     (out_ready),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MMU result memory model: byte at index i reads as 0xC0 + i.
  assign res_byte = 8'hC0 + {5'd0, res_idx};

  logic [30:0] w_obs;
  assign w_obs = {req_ready, mem_we, mem_waddr, mem_wdata, mmu_start, mmu_transpose,
                  out_valid, out_data, out_id, res_idx, busy, timeout_err};

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] data;
    logic        done;
    logic [30:0] exp;
  } vec_t;

  vec_t tv[22];

  function automatic logic [30:0] ex(input logic [1:0] rdy, input logic we, input logic [2:0] addr,
                                     input logic [7:0] wd, input logic st, input logic tr,
                                     input logic ov, input logic [7:0] od, input logic id,
                                     input logic [2:0] idx, input logic bsy, input logic tmo);
    return {rdy, we, addr, wd, st, tr, ov, od, id, idx, bsy, tmo};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_valid     = 2'b00;
    req_data      = 16'h0;
    req_transpose = 2'b00;
    mmu_done      = 1'b0;
    out_ready     = 1'b0;
    tick();
    tick();
    #1 chk("reset", 64'(w_obs), 64'd0);
    rst = 1'b0;
  endtask

  // Runs one job from its IDLE arbitration cycle through DRAIN (or WAIT timeout).
  task automatic run_job(input logic id, input logic [1:0] mask, input logic [7:0] base,
                         input logic tr, input int stall_k, input int stall_len,
                         input logic [3:0] ordy_pat, input bit no_done);
    logic [1:0] oh;
    logic       r;
    int         k;
    int         c;
    oh            = id ? 2'b10 : 2'b01;
    req_transpose = id ? {tr, ~tr} : {~tr, tr};
    req_valid     = mask;
    req_data      = {base, base};
    mmu_done      = 1'b0;
    out_ready     = 1'b1;
    #1 chk("idle_arb", 64'({busy, req_ready, mem_we}), 64'd0);
    tick();
    for (int b = 0; b < 8; b++) begin
      if (b == stall_k) begin
        for (int s = 0; s < stall_len; s++) begin
          req_valid = mask & ~oh;
          #1 chk("stall", 64'({busy, req_ready, mem_we, timeout_err}), 64'({1'b1, oh, 1'b0, 1'b0}));
          tick();
        end
      end
      req_valid = mask;
      req_data  = {8'(base + 8'(b)), 8'(base + 8'(b))};
      #1 chk($sformatf("beat%0d_id%0d", b, id), 64'({req_ready, mem_we, mem_waddr, mem_wdata}),
             64'({oh, 1'b1, 3'(b), 8'(base + 8'(b))}));
      tick();
    end
    #1 chk("start", 64'({mmu_start, mmu_transpose, req_ready, mem_we, busy}),
           64'({1'b1, tr, 2'b00, 1'b0, 1'b1}));
    tick();
    if (no_done) begin
      for (int j = 1; j < 15; j++) begin
        #1 chk($sformatf("wait%0d", j), 64'({busy, timeout_err, mmu_start}), 64'(3'b100));
        tick();
      end
      req_valid = 2'b00;
      #1 chk("timeout", 64'({busy, timeout_err}), 64'(2'b01));
      tick();
      #1 chk("timeout_pulse", 64'({busy, timeout_err}), 64'd0);
    end else begin
      for (int j = 0; j < 2; j++) begin
        #1 chk("wait", 64'({busy, mmu_start, out_valid}), 64'(3'b100));
        tick();
      end
      mmu_done = 1'b1;
      #1 chk("wait_done", 64'({busy, out_valid}), 64'(2'b10));
      tick();
      mmu_done = 1'b0;
      k = 0;
      c = 0;
      while (k < 8 && c < 40) begin
        r         = ordy_pat[c % 4];
        out_ready = r;
        #1 chk($sformatf("drain%0d_c%0d", k, c),
               64'({out_valid, out_data, out_id, res_idx, req_ready, mem_we}),
               64'({1'b1, 8'(8'hC0 + 8'(k)), id, 3'(k), 2'b00, 1'b0}));
        tick();
        if (r) k++;
        c++;
      end
      if (k != 8) chk("drain_bound", 64'(k), 64'd8);
      out_ready = 1'b1;
    end
  endtask

  initial begin
    // Test 1 table: req0 sends 1..8, done three cycles after start, full drain.
    tv[0] = '{2'b01, 16'h0, 1'b0, ex(2'b00, 0, 3'd0, 8'd0, 0, 0, 0, 8'd0, 0, 3'd0, 0, 0)};
    for (int k = 0; k < 8; k++)
      tv[1+k] = '{2'b01, {8'h00, 8'(k + 1)}, 1'b0,
                  ex(2'b01, 1, 3'(k), 8'(k + 1), 0, 0, 0, 8'd0, 0, 3'd0, 1, 0)};
    tv[9]  = '{2'b00, 16'h0, 1'b0, ex(2'b00, 0, 3'd0, 8'd0, 1, 0, 0, 8'd0, 0, 3'd0, 1, 0)};
    tv[10] = '{2'b00, 16'h0, 1'b0, ex(2'b00, 0, 3'd0, 8'd0, 0, 0, 0, 8'd0, 0, 3'd0, 1, 0)};
    tv[11] = '{2'b00, 16'h0, 1'b0, ex(2'b00, 0, 3'd0, 8'd0, 0, 0, 0, 8'd0, 0, 3'd0, 1, 0)};
    tv[12] = '{2'b00, 16'h0, 1'b1, ex(2'b00, 0, 3'd0, 8'd0, 0, 0, 0, 8'd0, 0, 3'd0, 1, 0)};
    for (int k = 0; k < 8; k++)
      tv[13+k] = '{2'b00, 16'h0, 1'b0,
                   ex(2'b00, 0, 3'd0, 8'd0, 0, 0, 1, 8'(8'hC0 + 8'(k)), 0, 3'(k), 1, 0)};
    tv[21] = '{2'b00, 16'h0, 1'b0, ex(2'b00, 0, 3'd0, 8'd0, 0, 0, 0, 8'd0, 0, 3'd0, 0, 0)};

    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      req_valid = tv[i].valid;
      req_data  = tv[i].data;
      mmu_done  = tv[i].done;
      #1 chk($sformatf("t1_vec%0d", i), 64'(w_obs), 64'(tv[i].exp));
      tick();
    end

    // Test 4: output backpressure 1,0,0,1 during drain.
    run_job(1'b0, 2'b01, 8'h40, 1'b0, -1, 0, 4'b1001, 1'b0);
    // Test 3: requester drops valid for 5 cycles after its third byte.
    run_job(1'b0, 2'b01, 8'h30, 1'b0, 3, 5, 4'b1111, 1'b0);

    // Test 2: both requesters pending from reset alternate jobs.
    do_reset();
    run_job(1'b0, 2'b11, 8'h50, 1'b0, -1, 0, 4'b1111, 1'b0);
    run_job(1'b1, 2'b11, 8'h60, 1'b1, -1, 0, 4'b1111, 1'b0);
    run_job(1'b0, 2'b11, 8'h70, 1'b0, -1, 0, 4'b1111, 1'b0);

    // Test 5: no done -> timeout, then the pointer favours req1.
    do_reset();
    run_job(1'b0, 2'b01, 8'h80, 1'b0, -1, 0, 4'b1111, 1'b1);
    run_job(1'b1, 2'b11, 8'h90, 1'b0, -1, 0, 4'b1111, 1'b0);

    // Test 6: reset mid-load discards the job, then req1 runs a transposed job.
    do_reset();
    req_valid     = 2'b01;
    req_transpose = 2'b01;
    req_data      = 16'h0;
    out_ready     = 1'b1;
    #1 chk("t6_idle", 64'(busy), 64'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      req_data = {8'h00, 8'(8'hE0 + 8'(b))};
      #1 chk($sformatf("t6_beat%0d", b), 64'({mem_we, mem_waddr, mem_wdata}),
             64'({1'b1, 3'(b), 8'(8'hE0 + 8'(b))}));
      tick();
    end
    req_valid = 2'b00;
    #1 chk("t6_pre_rst", 64'({mmu_transpose, busy, mem_we}), 64'(3'b110));
    rst = 1'b1;
    tick();
    #1 chk("t6_mid_rst", 64'(w_obs), 64'd0);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      #1 chk("t6_post_rst", 64'({mmu_start, busy, mmu_transpose}), 64'd0);
    end
    run_job(1'b1, 2'b10, 8'hA0, 1'b1, -1, 0, 4'b1111, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
